// File: rtl/wm_phase_timer_if.sv
// Signal bundle between the washing-machine controller and wm_phase_timer.
// Optional macro WM_PHASE_TIMER_EXTEND_EN adds the extend_Request line.
//
// Protocol: the controller (master) drives one-hot operation levels,
// fault and pause. Each level is held for as long as the matching state
// is active. The timer (slave) returns single-cycle registered pulses,
// which the controller samples on the following clock edge. No
// back-pressure exists, so no pulse is ever stretched or queued.
// phase and remaining are registered status outputs from the timer.
interface wm_phase_timer_if #(
   parameter int CNT_W = 16
);
   logic             fill_Water_Operation;
   logic             heat_Water_Operation;
   logic             wash_Operation;
   logic             rinse_Operation;
   logic             spin_Operation;
   logic             fault;
   logic             pause;
`ifdef WM_PHASE_TIMER_EXTEND_EN
   logic             extend_Request;
`endif
   logic             sig_Time_Out;
   logic             sig_Wash_Completed;
   logic             sig_Rinse_Completed;
   logic             sig_Spin_Completed;
   logic [2:0]       phase;
   logic [CNT_W-1:0] remaining;

   modport master (
      output fill_Water_Operation, heat_Water_Operation, wash_Operation,
      output rinse_Operation, spin_Operation, fault, pause,
`ifdef WM_PHASE_TIMER_EXTEND_EN
      output extend_Request,
`endif
      input  sig_Time_Out, sig_Wash_Completed, sig_Rinse_Completed,
      input  sig_Spin_Completed, phase, remaining
   );

   modport slave (
      input  fill_Water_Operation, heat_Water_Operation, wash_Operation,
      input  rinse_Operation, spin_Operation, fault, pause,
`ifdef WM_PHASE_TIMER_EXTEND_EN
      input  extend_Request,
`endif
      output sig_Time_Out, sig_Wash_Completed, sig_Rinse_Completed,
      output sig_Spin_Completed, phase, remaining
   );
endinterface

// File: rtl/wm_phase_timer.sv
// Phase timing scheduler for the washing-machine controller.
// The block decodes the active operation and runs a prescaled down-counter.
// When the counter expires it issues a one-cycle timeout or completion pulse.
// Optional macro WM_PHASE_TIMER_EXTEND_EN adds EXTEND_TICKS and extend_Request.
// With that macro, a request in wash, rinse or spin lengthens the phase.
module wm_phase_timer #(
   parameter int CNT_W        = 16,
   parameter int CLK_PER_TICK = 1000,
   parameter int FILL_LIMIT   = 60,
   parameter int HEAT_LIMIT   = 120,
   parameter int WASH_TIME    = 300,
   parameter int RINSE_TIME   = 180,
   parameter int SPIN_TIME    = 120
`ifdef WM_PHASE_TIMER_EXTEND_EN
   , parameter int EXTEND_TICKS = 60
`endif
) (
   input  logic           clock,
   input  logic           reset_n,
   wm_phase_timer_if.slave bus
);

   // Phase codes; phase doubles as the observable state of this block.
   localparam logic [2:0] PH_IDLE  = 3'd0;
   localparam logic [2:0] PH_FILL  = 3'd2;
   localparam logic [2:0] PH_HEAT  = 3'd3;
   localparam logic [2:0] PH_WASH  = 3'd4;
   localparam logic [2:0] PH_RINSE = 3'd5;
   localparam logic [2:0] PH_SPIN  = 3'd6;

   localparam int            PW         = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_TICK - 1);

   logic [2:0]       phase_dec;
   logic [CNT_W-1:0] limit_dec;
   logic [2:0]       phase_q;
   logic [CNT_W-1:0] remaining_q;
   logic [PW-1:0]    presc_q;
   logic             done_q;
   logic             time_out_q;
   logic             wash_done_q;
   logic             rinse_done_q;
   logic             spin_done_q;

   logic             phase_change;
   logic             running;
   logic             tick;
   logic             ext_hit;
   logic [CNT_W-1:0] ext_val;
   logic [CNT_W-1:0] rem_next;
   logic             expire;

   // Priority decode of the controller state; fault or no operation means idle.
   always_comb begin
      phase_dec = PH_IDLE;
      limit_dec = '0;
      if (bus.fault) begin
         phase_dec = PH_IDLE;
      end else if (bus.spin_Operation) begin
         phase_dec = PH_SPIN;
         limit_dec = CNT_W'(SPIN_TIME);
      end else if (bus.rinse_Operation) begin
         phase_dec = PH_RINSE;
         limit_dec = CNT_W'(RINSE_TIME);
      end else if (bus.wash_Operation) begin
         phase_dec = PH_WASH;
         limit_dec = CNT_W'(WASH_TIME);
      end else if (bus.heat_Water_Operation) begin
         phase_dec = PH_HEAT;
         limit_dec = CNT_W'(HEAT_LIMIT);
      end else if (bus.fill_Water_Operation) begin
         phase_dec = PH_FILL;
         limit_dec = CNT_W'(FILL_LIMIT);
      end
   end

   assign phase_change = (phase_dec != phase_q);
   assign running      = (phase_q != PH_IDLE) && !done_q && !bus.pause;
   assign tick         = running && (presc_q == PRESC_LAST);

`ifdef WM_PHASE_TIMER_EXTEND_EN
   // Extension applies only to wash, rinse and spin, before expiry.
   // Pause is not a blocking condition: pause only freezes the tick count.
   logic [CNT_W+31:0] ext_sum;
   assign ext_hit = bus.extend_Request && !done_q && !phase_change &&
                    ((phase_q == PH_WASH) || (phase_q == PH_RINSE) || (phase_q == PH_SPIN));
   assign ext_sum = {32'd0, remaining_q} + (CNT_W+32)'(EXTEND_TICKS) - (CNT_W+32)'(tick);
   assign ext_val = (ext_sum[CNT_W+31:CNT_W] != '0) ? '1 : ext_sum[CNT_W-1:0];
`else
   assign ext_hit = 1'b0;
   assign ext_val = '0;
`endif

   // Next counter value; an extension absorbs a coinciding tick without expiring.
   always_comb begin
      rem_next = remaining_q;
      expire   = 1'b0;
      if (ext_hit) begin
         rem_next = ext_val;
      end else if (tick) begin
         rem_next = remaining_q - CNT_W'(1);
         expire   = !phase_change && (remaining_q == CNT_W'(1));
      end
   end

   // Phase register, down-counter, prescaler and done flag; a phase change wins.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         phase_q     <= PH_IDLE;
         remaining_q <= '0;
         presc_q     <= '0;
         done_q      <= 1'b0;
      end else if (phase_change) begin
         phase_q     <= phase_dec;
         remaining_q <= limit_dec;
         presc_q     <= '0;
         done_q      <= 1'b0;
      end else begin
         if (running) begin
            presc_q <= tick ? '0 : presc_q + PW'(1);
         end
         remaining_q <= rem_next;
         if (expire) begin
            done_q <= 1'b1;
         end
      end
   end

   // Single-cycle pulse registers; only the running phase's pulse can fire.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         time_out_q   <= 1'b0;
         wash_done_q  <= 1'b0;
         rinse_done_q <= 1'b0;
         spin_done_q  <= 1'b0;
      end else begin
         time_out_q   <= expire && ((phase_q == PH_FILL) || (phase_q == PH_HEAT));
         wash_done_q  <= expire && (phase_q == PH_WASH);
         rinse_done_q <= expire && (phase_q == PH_RINSE);
         spin_done_q  <= expire && (phase_q == PH_SPIN);
      end
   end

   assign bus.sig_Time_Out        = time_out_q;
   assign bus.sig_Wash_Completed  = wash_done_q;
   assign bus.sig_Rinse_Completed = rinse_done_q;
   assign bus.sig_Spin_Completed  = spin_done_q;
   assign bus.phase               = phase_q;
   assign bus.remaining           = remaining_q;

endmodule

// File: tb/tb_wm_phase_timer.sv
// Testbench for wm_phase_timer: directed scenarios followed by randomized
// operation sequences, all checked against a reference model that counts
// un-paused active cycles per phase.
module tb_wm_phase_timer;

   localparam int CNT_W   = 16;
   localparam int CPT     = 4;
   localparam int FILL_L  = 2;
   localparam int HEAT_L  = 3;
   localparam int WASH_T  = 3;
   localparam int RINSE_T = 5;
   localparam int SPIN_T  = 4;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset_n;
   always #5 clock = ~clock;

   wm_phase_timer_if #(.CNT_W(CNT_W)) bus ();

   wm_phase_timer #(
      .CNT_W(CNT_W), .CLK_PER_TICK(CPT), .FILL_LIMIT(FILL_L), .HEAT_LIMIT(HEAT_L),
      .WASH_TIME(WASH_T), .RINSE_TIME(RINSE_T), .SPIN_TIME(SPIN_T)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .bus(bus)
   );

   int checks   = 0;
   int failures = 0;

   // ---------------- reference model ----------------
   // m_active = clock edges spent running (not paused, not expired) in the phase.
   int m_phase  = 0;
   int m_active = 0;
   int m_pulse  = 0; // 0 none, 1 time out, 2 wash, 3 rinse, 4 spin

   function automatic int decode_ops();
      if (bus.fault)                return 0;
      if (bus.spin_Operation)       return 6;
      if (bus.rinse_Operation)      return 5;
      if (bus.wash_Operation)       return 4;
      if (bus.heat_Water_Operation) return 3;
      if (bus.fill_Water_Operation) return 2;
      return 0;
   endfunction

   function automatic int limit_of(input int ph);
      case (ph)
         2: return FILL_L;
         3: return HEAT_L;
         4: return WASH_T;
         5: return RINSE_T;
         6: return SPIN_T;
         default: return 0;
      endcase
   endfunction

   function automatic int pulse_of(input int ph);
      case (ph)
         2, 3: return 1;
         4:    return 2;
         5:    return 3;
         6:    return 4;
         default: return 0;
      endcase
   endfunction

   function automatic int exp_remaining();
      if (m_phase == 0) return 0;
      return limit_of(m_phase) - m_active / CPT;
   endfunction

   task automatic model_reset();
      m_phase  = 0;
      m_active = 0;
      m_pulse  = 0;
   endtask

   task automatic model_step();
      int d;
      d = decode_ops();
      m_pulse = 0;
      if (d != m_phase) begin
         m_phase  = d;
         m_active = 0;
      end else if (m_phase != 0 && !bus.pause && m_active < limit_of(m_phase) * CPT) begin
         m_active++;
         if (m_active == limit_of(m_phase) * CPT) m_pulse = pulse_of(m_phase);
      end
   endtask

   // ---------------- scoreboard ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      int n;
      n = int'(bus.sig_Time_Out) + int'(bus.sig_Wash_Completed) +
          int'(bus.sig_Rinse_Completed) + int'(bus.sig_Spin_Completed);
      check("phase",      32'(bus.phase),      32'(m_phase));
      check("remaining",  32'(bus.remaining),  32'(exp_remaining()));
      check("time_out",   32'(bus.sig_Time_Out),        32'(m_pulse == 1));
      check("wash_done",  32'(bus.sig_Wash_Completed),  32'(m_pulse == 2));
      check("rinse_done", 32'(bus.sig_Rinse_Completed), 32'(m_pulse == 3));
      check("spin_done",  32'(bus.sig_Spin_Completed),  32'(m_pulse == 4));
      check("one_pulse",  32'(n <= 1), 32'd1);
   endtask

   // ---------------- driver tasks ----------------
   // mask = {fault, spin, rinse, wash, heat, fill}
   task automatic drive_ops(input logic [5:0] mask);
      bus.fill_Water_Operation = mask[0];
      bus.heat_Water_Operation = mask[1];
      bus.wash_Operation       = mask[2];
      bus.rinse_Operation      = mask[3];
      bus.spin_Operation       = mask[4];
      bus.fault                = mask[5];
   endtask

   // One clock: model follows the edge, DUT sampled 1 time unit later.
   task automatic step();
      @(posedge clock);
      model_step();
      #1;
      check_all();
   endtask

   // Steps until the selected pulse appears; returns edges taken or -1.
   task automatic wait_pulse(input int kind, input int bound, output int lat);
      lat = -1;
      for (int i = 1; i <= bound; i++) begin
         step();
         if ((kind == 1 && bus.sig_Time_Out) || (kind == 2 && bus.sig_Wash_Completed) ||
             (kind == 3 && bus.sig_Rinse_Completed) || (kind == 4 && bus.sig_Spin_Completed)) begin
            lat = i;
            break;
         end
      end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin
      int lat;
      int cnt;
      int frozen;
      logic [5:0] mask;
      int len;

      reset_n = 1'b0;
      drive_ops(6'b0);
      bus.pause = 1'b0;
`ifdef WM_PHASE_TIMER_EXTEND_EN
      bus.extend_Request = 1'b0;
`endif
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      check("reset_phase",     32'(bus.phase), 32'd0);
      check("reset_remaining", 32'(bus.remaining), 32'd0);
      check("reset_pulses",    32'({bus.sig_Time_Out, bus.sig_Wash_Completed,
                                    bus.sig_Rinse_Completed, bus.sig_Spin_Completed}), 32'd0);
      reset_n = 1'b1;
      step();

      // Wash from idle: load, 12-edge latency, no second pulse.
      drive_ops(6'b000100);
      step();
      check("t1_entry_phase", 32'(bus.phase), 32'd4);
      check("t1_entry_rem",   32'(bus.remaining), 32'(WASH_T));
      wait_pulse(2, 60, lat);
      check("t1_latency", 32'(lat), 32'(WASH_T * CPT));
      repeat (10) step();
      check("t1_rem_hold", 32'(bus.remaining), 32'd0);
      drive_ops(6'b0);
      step();

      // Fill timeout, then heat reload with no pulse.
      drive_ops(6'b000001);
      step();
      wait_pulse(1, 60, lat);
      check("t2_latency", 32'(lat), 32'(FILL_L * CPT));
      repeat (6) step();
      drive_ops(6'b000010);
      step();
      check("t2_heat_rem", 32'(bus.remaining), 32'(HEAT_L));
      check("t2_no_pulse", 32'(bus.sig_Time_Out), 32'd0);
      drive_ops(6'b0);
      step();

      // Rinse paused for 20 cycles mid-phase.
      drive_ops(6'b001000);
      step();
      cnt = 0;
      repeat (6) begin step(); cnt++; end
      frozen = int'(bus.remaining);
      bus.pause = 1'b1;
      repeat (20) begin
         step();
         cnt++;
         check("t3_frozen", 32'(bus.remaining), 32'(frozen));
      end
      bus.pause = 1'b0;
      wait_pulse(3, 100, lat);
      if (lat > 0) cnt += lat; else cnt = -1;
      check("t3_latency", 32'(cnt), 32'(RINSE_T * CPT + 20));
      drive_ops(6'b0);
      step();

      // Spin: fault on the edge that would expire it.
      drive_ops(6'b010000);
      step();
      for (int i = 0; i < 100 && m_active < SPIN_T * CPT - 1; i++) step();
      check("t4_reached", 32'(m_active), 32'(SPIN_T * CPT - 1));
      drive_ops(6'b110000);
      step();
      check("t4_phase",    32'(bus.phase), 32'd0);
      check("t4_rem",      32'(bus.remaining), 32'd0);
      check("t4_no_spin",  32'(bus.sig_Spin_Completed), 32'd0);
      repeat (3) step();
      drive_ops(6'b0);
      step();

      // Asynchronous reset mid-wash with remaining==2.
      drive_ops(6'b000100);
      step();
      for (int i = 0; i < 100 && m_active < CPT; i++) step();
      check("t5_rem_before", 32'(bus.remaining), 32'd2);
      #2;
      reset_n = 1'b0;
      drive_ops(6'b0);
      #1;
      model_reset();
      check("t5_async_phase", 32'(bus.phase), 32'd0);
      check("t5_async_rem",   32'(bus.remaining), 32'd0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      drive_ops(6'b000100);
      step();
      check("t5_reload", 32'(bus.remaining), 32'(WASH_T));

      // Randomized operation sequences, including overlapping requests.
      for (int seg = 0; seg < 200; seg++) begin
         case ($urandom_range(0, 9))
            0:       mask = 6'b0;
            1:       mask = 6'($urandom_range(0, 63));
            default: mask = 6'(1 << $urandom_range(0, 4));
         endcase
         if ($urandom_range(0, 19) == 0) mask[5] = 1'b1;
         drive_ops(mask);
         len = $urandom_range(1, 70);
         for (int c = 0; c < len; c++) begin
            if ($urandom_range(0, 7) == 0) bus.pause = ~bus.pause;
            step();
         end
      end
      bus.pause = 1'b0;
      drive_ops(6'b0);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wm_phase_timer.md
Name: wm_phase_timer

Overview:
- Phase timing scheduler for the washing-machine controller FSM.
- Watches the controller's one-hot operation outputs and runs a prescaled down-counter for the active phase.
- Generates the completion and timeout pulses the controller consumes:
  - sig_Time_Out during fill and heat.
  - sig_Wash_Completed, sig_Rinse_Completed and sig_Spin_Completed at the end of the matching phase.
- Sits between the controller outputs and the controller's sig_* inputs.

Parameters:
- CNT_W, 16: width of the tick counter and of `remaining`.
- CLK_PER_TICK, 1000: clock cycles per timer tick. Must be ≥1.
- FILL_LIMIT, 60: ticks allowed in fill before timeout. Must be ≥1.
- HEAT_LIMIT, 120: ticks allowed in heat before timeout. Must be ≥1.
- WASH_TIME, 300: wash duration in ticks. Must be ≥1.
- RINSE_TIME, 180: rinse duration in ticks. Must be ≥1.
- SPIN_TIME, 120: spin duration in ticks. Must be ≥1.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- fill_Water_Operation  in  1  controller is in the fill state.
- heat_Water_Operation  in  1  controller is in the heat state.
- wash_Operation  in  1  controller is in the wash state.
- rinse_Operation  in  1  controller is in the rinse state.
- spin_Operation  in  1  controller is in the spin state.
- fault  in  1  controller is in the fault state.
- pause  in  1  freeze timing (lid opened). Level-sensitive.
- sig_Time_Out  out  1  one-cycle pulse when the fill or heat limit expires.
- sig_Wash_Completed  out  1  one-cycle pulse.
- sig_Rinse_Completed  out  1  one-cycle pulse.
- sig_Spin_Completed  out  1  one-cycle pulse.
- phase  out  3  registered phase code: 0 idle, 2 fill, 3 heat, 4 wash, 5 rinse, 6 spin.
- remaining  out  CNT_W  ticks left in the current phase.

Behaviour:
- Reset (asynchronous, reset_n=0): all outputs 0, prescaler 0, done flag 0. Reset mid-phase discards all timing; no pulse is issued.
- Phase decode (combinational), priority fault > spin > rinse > wash > heat > fill:
  - fault=1 or no operation input asserted decodes as idle (0).
- Phase change: when the decoded phase ≠ `phase` register, on that clock:
  - `phase` updates to the new code;
  - `remaining` loads the phase limit (0 for idle);
  - prescaler clears;
  - done flag clears.
  - A phase change takes priority over any tick or expiry in the same cycle; no pulse is issued.
- Prescaler: counts 0..CLK_PER_TICK-1 while phase≠idle, pause=0 and done=0. A tick occurs in the cycle where the count equals CLK_PER_TICK-1; the count then wraps to 0.
- On a tick, `remaining` decrements by 1.
- Expiry: a tick with remaining==1 sets remaining=0 and done=1. On that same clock edge the phase's pulse register is set, so the pulse is high for exactly the next cycle:
  - fill or heat: sig_Time_Out;
  - wash: sig_Wash_Completed;
  - rinse: sig_Rinse_Completed;
  - spin: sig_Spin_Completed.
- After expiry, done=1 holds the counter at 0 and blocks any further pulse until the next phase change.
- Pause: prescaler and `remaining` hold their values. Phase decode and phase-change reload still act during pause.
- Idle: remaining=0, no pulses, prescaler held at 0.
- At most one pulse output is high in any cycle.
- All outputs are registered. The pulse is 1 cycle wide, and the controller samples it on the following edge.

Optional Feature:
- Macro WM_PHASE_TIMER_EXTEND_EN. Adds parameter EXTEND_TICKS (default 60) and input port extend_Request (1 bit, pulse).
- Defined:
  - extend_Request=1 in wash, rinse or spin with done=0 adds EXTEND_TICKS to `remaining`, saturating at 2^CNT_W-1.
  - If it coincides with a tick, result = remaining+EXTEND_TICKS-1, saturating; no expiry occurs that cycle.
  - Ignored in idle, fill and heat, when done=1, and in a phase-change cycle.
- Undefined: port and parameter absent; behaviour as above.

Test Plan:
1. CLK_PER_TICK=4, WASH_TIME=3; assert wash_Operation from idle.
   -> Cycle after entry: phase=4, remaining=3. Decrements every 4 cycles. sig_Wash_Completed high for 1 cycle, 12 cycles after load. remaining stays 0 with no second pulse.
2. FILL_LIMIT=2, hold fill_Water_Operation.
   -> sig_Time_Out pulses once after 8 cycles. Switching to heat_Water_Operation reloads remaining=HEAT_LIMIT with no pulse.
3. Rinse with RINSE_TIME=5; assert pause for 20 cycles mid-phase.
   -> remaining frozen during pause. The completion pulse is delayed by exactly 20 cycles.
4. Spin running; assert fault in the cycle the expiry tick would occur.
   -> phase=0, remaining=0, and no sig_Spin_Completed.
5. Pull reset_n low mid-wash with remaining=2.
   -> All outputs 0 immediately (asynchronous). After release, re-asserting wash_Operation reloads WASH_TIME.
6. (WM_PHASE_TIMER_EXTEND_EN, EXTEND_TICKS=4) Pulse extend_Request in wash with remaining=1 on a tick cycle.
   -> remaining=4 and no pulse. Repeating it with CNT_W=4 and remaining=14 saturates remaining at 15.
